// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a shared FP add/mul unit.
// Each granted command holds the unit for LATENCY cycles, then waits in RESP until accepted.
module fpu_arbiter #(
   parameter int unsigned LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [130:0] req0_cmd,
   input  logic [130:0] req1_cmd,
   output logic [1:0]   fpu_operation,
   output logic         fpu_mode,
   output logic [63:0]  fpu_x,
   output logic [63:0]  fpu_y,
   input  logic [31:0]  fpu_result32,
   input  logic [63:0]  fpu_result64,
   input  logic         fpu_overflow,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [63:0]  rsp_data,
   output logic         rsp_overflow,
   output logic         rsp_err,
   output logic [15:0]  done_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [1:0]    op_q, op_d;
   logic          mode_q, mode_d;
   logic [63:0]   x_q, x_d;
   logic [63:0]   y_q, y_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          id_q, id_d;
   logic [63:0]   data_q, data_d;
   logic          ovf_q, ovf_d;
   logic          err_q, err_d;
   logic [15:0]   done_q, done_d;

   logic [1:0]    grant;
   logic          hs;
   logic          sel;
   logic [130:0]  sel_cmd;
   logic [1:0]    sel_op;
   logic          sel_legal;

   // A requester wins when it is alone, or when both contend and the other one was served last.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_grant
         assign grant[gi] = (state_q == IDLE) && !rst && req_valid[gi] &&
                            (!req_valid[1 - gi] || (last_q != 1'(gi)));
      end
   endgenerate

   assign hs        = |grant;
   assign sel       = grant[1];
   assign sel_cmd   = sel ? req1_cmd : req0_cmd;
   assign sel_op    = sel_cmd[130:129];
   assign sel_legal = (sel_op == 2'd1) || (sel_op == 2'd2);

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      op_d    = op_q;
      mode_d  = mode_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      data_d  = data_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      done_d  = done_q;
      case (state_q)
         IDLE: begin
            if (hs) begin
               last_d = sel;
               id_d   = sel;
               op_d   = sel_op;
               if (sel_legal) begin
                  mode_d  = sel_cmd[128];
                  x_d     = sel_cmd[127:64];
                  y_d     = sel_cmd[63:0];
                  cnt_d   = CNT_LOAD;
                  state_d = ISSUE;
               end else begin
                  // Undefined opcodes never reach the unit; the operand drive keeps its old value.
                  data_d  = 64'd0;
                  ovf_d   = 1'b0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         ISSUE: begin
            if (cnt_q == 4'd0) begin
               data_d  = mode_q ? fpu_result64 : {32'd0, fpu_result32};
               ovf_d   = fpu_overflow;
               err_d   = 1'b0;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               done_d  = done_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         op_q    <= 2'd0;
         mode_q  <= 1'b0;
         x_q     <= 64'd0;
         y_q     <= 64'd0;
         cnt_q   <= 4'd0;
         id_q    <= 1'b0;
         data_q  <= 64'd0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         op_q    <= op_d;
         mode_q  <= mode_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         data_q  <= data_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         done_q  <= done_d;
      end
   end

   assign req_ready     = grant;
   assign fpu_operation = (state_q == ISSUE) ? op_q : 2'd0;
   assign fpu_mode      = mode_q;
   assign fpu_x         = x_q;
   assign fpu_y         = y_q;
   assign rsp_valid     = (state_q == RESP);
   assign rsp_id        = id_q;
   assign rsp_data      = data_q;
   assign rsp_overflow  = ovf_q;
   assign rsp_err       = err_q;
   assign done_count    = done_q;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: FP-unit stand-in, queue scoreboard, directed cases and random traffic.
module tb_fpu_arbiter;

   localparam int LAT = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   req_valid = 2'b00;
   logic [1:0]   req_ready;
   logic [130:0] req0_cmd = '0;
   logic [130:0] req1_cmd = '0;
   logic [1:0]   fpu_operation;
   logic         fpu_mode;
   logic [63:0]  fpu_x, fpu_y;
   logic [31:0]  fpu_result32;
   logic [63:0]  fpu_result64;
   logic         fpu_overflow;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic         rsp_id;
   logic [63:0]  rsp_data;
   logic         rsp_overflow, rsp_err;
   logic [15:0]  done_count;

   fpu_arbiter #(.LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
      .fpu_operation(fpu_operation), .fpu_mode(fpu_mode), .fpu_x(fpu_x), .fpu_y(fpu_y),
      .fpu_result32(fpu_result32), .fpu_result64(fpu_result64), .fpu_overflow(fpu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_overflow(rsp_overflow), .rsp_err(rsp_err), .done_count(done_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Stand-in for the FP unit: {overflow, result32, result64}. The 1.0+2.0 single case is exact.
   function automatic logic [96:0] fp_model(input logic [1:0] op, input logic mode,
                                            input logic [63:0] x, input logic [63:0] y);
      logic [63:0] r64;
      logic [31:0] r32;
      logic        ov;
      r64 = (op == 2'd1) ? x + y : x * y;
      r32 = r64[31:0] ^ r64[63:32];
      if (op == 2'd1 && !mode && x[31:0] == 32'h3F80_0000 && y[31:0] == 32'h4000_0000)
         r32 = 32'h4040_0000;
      ov = x[0] ^ y[0] ^ op[1];
      return {ov, r32, r64};
   endfunction

   // The unit's outputs are only meaningful once operands have been held for LATENCY cycles.
   logic [1:0]  prev_op;
   logic        prev_mode;
   logic [63:0] prev_x, prev_y;
   int          stable_cnt = 0;
   logic [96:0] stub;

   always @(posedge clk) begin
      prev_op   <= fpu_operation;
      prev_mode <= fpu_mode;
      prev_x    <= fpu_x;
      prev_y    <= fpu_y;
      if (fpu_operation == 2'd0)
         stable_cnt <= 0;
      else if (fpu_operation == prev_op && fpu_mode == prev_mode && fpu_x == prev_x && fpu_y == prev_y)
         stable_cnt <= stable_cnt + 1;
      else
         stable_cnt <= 1;
   end

   always_comb begin
      stub = fp_model(fpu_operation, fpu_mode, fpu_x, fpu_y);
      if (fpu_operation == 2'd0 || stable_cnt < LAT - 1)
         stub = stub ^ {1'b1, 32'h5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5};
   end
   assign {fpu_overflow, fpu_result32, fpu_result64} = stub;

   // Reference model: one outstanding job at a time, round-robin on contention.
   typedef struct {
      logic         id;
      logic         legal;
      logic [130:0] cmd;
      logic [63:0]  data;
      logic         ovf;
      logic         err;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur;
   logic        busy_m = 1'b0;
   logic        rsp_act = 1'b0;
   logic        last_m = 1'b1;
   logic [15:0] done_m = 16'd0;
   int          acc_cyc = 0;
   logic        grant_log[$];
   logic [63:0] last_data;
   logic        last_id, last_ovf, last_err;
   int          last_lat;

   function automatic logic [1:0] rr_grant(input logic [1:0] v, input logic last);
      if (v == 2'b11) return last ? 2'b01 : 2'b10;
      return v;
   endfunction

   initial begin : monitor
      logic [1:0]  g_exp;
      logic [96:0] ref_r;
      exp_t        e;
      int          k;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_m  = 1'b0;
            rsp_act = 1'b0;
            last_m  = 1'b1;
            done_m  = 16'd0;
            exp_q.delete();
         end else begin
            g_exp = busy_m ? 2'b00 : rr_grant(req_valid, last_m);
            chk("req_ready", 64'(req_ready), 64'(g_exp));
            chk("done_count", 64'(done_count), 64'(done_m));
            k = cyc - acc_cyc;
            if (busy_m && exp_q.size() > 0 && exp_q[0].legal && !rsp_act && k >= 1 && k <= LAT) begin
               chk("fpu_operation", 64'(fpu_operation), 64'(exp_q[0].cmd[130:129]));
               chk("fpu_mode", 64'(fpu_mode), 64'(exp_q[0].cmd[128]));
               chk("fpu_x", fpu_x, exp_q[0].cmd[127:64]);
               chk("fpu_y", fpu_y, exp_q[0].cmd[63:0]);
            end else begin
               chk("fpu_op_idle", 64'(fpu_operation), 64'd0);
            end
            if (!busy_m) begin
               chk("spurious_rsp", 64'(rsp_valid), 64'd0);
            end else if (rsp_valid) begin
               if (!rsp_act) begin
                  rsp_act = 1'b1;
                  if (exp_q.size() == 0) begin
                     chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
                  end else begin
                     cur = exp_q.pop_front();
                     chk("rsp_latency", 64'(k), cur.legal ? 64'(LAT + 1) : 64'd1);
                  end
                  last_lat  = k;
                  last_data = rsp_data;
                  last_id   = rsp_id;
                  last_ovf  = rsp_overflow;
                  last_err  = rsp_err;
               end
               chk("rsp_id", 64'(rsp_id), 64'(cur.id));
               chk("rsp_data", rsp_data, cur.data);
               chk("rsp_overflow", 64'(rsp_overflow), 64'(cur.ovf));
               chk("rsp_err", 64'(rsp_err), 64'(cur.err));
            end else if (k > LAT + 1) begin
               chk("rsp_timeout", 64'(rsp_valid), 64'd1);
               void'(exp_q.pop_front());
               busy_m = 1'b0;
            end

            if ((req_valid & req_ready) != 2'b00) grant_log.push_back(req_ready[1]);

            if (busy_m && rsp_act && rsp_valid && rsp_ready) begin
               $display("RSP id=%0d data=%h ovf=%0d err=%0d lat=%0d done=%0d",
                        rsp_id, rsp_data, rsp_overflow, rsp_err, last_lat, done_m + 16'd1);
               busy_m  = 1'b0;
               rsp_act = 1'b0;
               done_m  = done_m + 16'd1;
            end else if (!busy_m && g_exp != 2'b00) begin
               e.id    = g_exp[1];
               e.cmd   = g_exp[1] ? req1_cmd : req0_cmd;
               e.legal = (e.cmd[130:129] == 2'd1) || (e.cmd[130:129] == 2'd2);
               ref_r   = fp_model(e.cmd[130:129], e.cmd[128], e.cmd[127:64], e.cmd[63:0]);
               if (e.legal) begin
                  e.data = e.cmd[128] ? ref_r[63:0] : {32'd0, ref_r[95:64]};
                  e.ovf  = ref_r[96];
                  e.err  = 1'b0;
               end else begin
                  e.data = 64'd0;
                  e.ovf  = 1'b0;
                  e.err  = 1'b1;
               end
               exp_q.push_back(e);
               busy_m  = 1'b1;
               last_m  = g_exp[1];
               acc_cyc = cyc;
            end
         end
      end
   end

   function automatic logic [130:0] rand_cmd(input bit legal_only);
      logic [1:0]  op;
      logic [63:0] x, y;
      op = legal_only ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
      x  = {$urandom, $urandom};
      y  = {$urandom, $urandom};
      return {op, 1'($urandom_range(0, 1)), x, y};
   endfunction

   task automatic wait_idle(output bit saw_op);
      bit ok;
      ok     = 1'b0;
      saw_op = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (fpu_operation != 2'd0) saw_op = 1'b1;
         if (!busy_m && !rsp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_idle", 64'(ok), 64'd1);
   endtask

   initial begin : driver
      bit          saw;
      bit          got;
      logic [15:0] done_before;
      logic [63:0] mx, my;
      logic [96:0] mul_ref;

      // Reset values, with both requesters asserting.
      req_valid = 2'b11;
      req0_cmd  = rand_cmd(1'b1);
      req1_cmd  = rand_cmd(1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      chk("rst_rsp_overflow", 64'(rsp_overflow), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_done_count", 64'(done_count), 64'd0);
      chk("rst_fpu_operation", 64'(fpu_operation), 64'd0);
      chk("rst_fpu_mode", 64'(fpu_mode), 64'd0);
      chk("rst_fpu_x", fpu_x, 64'd0);
      chk("rst_fpu_y", fpu_y, 64'd0);
      @(posedge clk); #1;
      rst       = 1'b0;
      req_valid = 2'b00;

      // Reset while the unit is being driven.
      @(posedge clk); #1;
      req_valid = 2'b01;
      req0_cmd  = {2'd1, 1'b1, 64'h4010_0000_0000_0000, 64'h4020_0000_0000_0000};
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b00;
      chk("mid_issue_op", 64'(fpu_operation), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_fpu_operation", 64'(fpu_operation), 64'd0);
      chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort_done_count", 64'(done_count), 64'd0);
      chk("abort_fpu_x", fpu_x, 64'd0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
      end

      // Contention: both valid every cycle for four grants.
      grant_log.delete();
      @(posedge clk); #1;
      req0_cmd  = rand_cmd(1'b1);
      req1_cmd  = rand_cmd(1'b1);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int i = 0; i < 100 && grant_log.size() < 4; i++) begin
         @(posedge clk); #1;
      end
      req_valid = 2'b00;
      wait_idle(saw);
      chk("contention_grants", 64'(grant_log.size()), 64'd4);
      if (grant_log.size() >= 4) begin
         chk("grant0", 64'(grant_log[0]), 64'd0);
         chk("grant1", 64'(grant_log[1]), 64'd1);
         chk("grant2", 64'(grant_log[2]), 64'd0);
         chk("grant3", 64'(grant_log[3]), 64'd1);
      end
      @(negedge clk);
      chk("contention_done", 64'(done_count), 64'd4);

      // Single-precision add 1.0 + 2.0.
      @(posedge clk); #1;
      req0_cmd  = {2'd1, 1'b0, 64'h0000_0000_3F80_0000, 64'h0000_0000_4000_0000};
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_idle(saw);
      chk("add_data", last_data, 64'h0000_0000_4040_0000);
      chk("add_id", 64'(last_id), 64'd0);
      chk("add_latency", 64'(last_lat), 64'(LAT + 1));

      // Backpressure: hold the response while both requesters knock.
      @(posedge clk); #1;
      done_before = done_count;
      rsp_ready   = 1'b0;
      req0_cmd    = rand_cmd(1'b1);
      req1_cmd    = rand_cmd(1'b1);
      req_valid   = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b11;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1'b1;
            break;
         end
      end
      chk("bp_rsp_seen", 64'(got), 64'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_done_held", 64'(done_count), 64'(done_before));
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      req_valid = 2'b00;
      wait_idle(saw);
      chk("bp_single_completion", 64'(done_count), 64'(done_before + 16'd1));

      // Illegal opcode from requester 1.
      @(posedge clk); #1;
      req1_cmd  = {2'd3, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
      req_valid = 2'b10;
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_idle(saw);
      chk("illegal_err", 64'(last_err), 64'd1);
      chk("illegal_data", last_data, 64'd0);
      chk("illegal_id", 64'(last_id), 64'd1);
      chk("illegal_latency", 64'(last_lat), 64'd1);
      chk("illegal_fpu_quiet", 64'(saw), 64'd0);

      // Double-precision multiply reporting overflow.
      mx = 64'h7FE0_0000_0000_0003;
      my = 64'h4000_0000_0000_0001;
      mul_ref = fp_model(2'd2, 1'b1, mx, my);
      @(posedge clk); #1;
      req0_cmd  = {2'd2, 1'b1, mx, my};
      req_valid = 2'b01;
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_idle(saw);
      chk("dmul_overflow", 64'(last_ovf), 64'd1);
      chk("dmul_data", last_data, mul_ref[63:0]);

      // Random traffic, including illegal opcodes, drops before grant and backpressure.
      for (int c = 0; c < 2000; c++) begin
         @(posedge clk); #1;
         req_valid = 2'($urandom_range(0, 3));
         req0_cmd  = rand_cmd($urandom_range(0, 4) != 0);
         req1_cmd  = rand_cmd($urandom_range(0, 4) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      wait_idle(saw);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the cycles the FP unit needs with operands/operation held stable before its result is captured (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2, per-requester accept; at most one bit high.
REQ-006 The block SHALL have ports req0_cmd and req1_cmd, input, 131 each, packed as {op[130:129], mode[128], x[127:64], y[63:0]}; op 1=add, 2=mul; mode 0=single, 1=double.
REQ-007 The block SHALL have ports fpu_operation (output, 2), fpu_mode (output, 1), fpu_x (output, 64) and fpu_y (output, 64), the drive to the shared FP add/mul unit.
REQ-008 The block SHALL have ports fpu_result32 (input, 32), fpu_result64 (input, 64) and fpu_overflow (input, 1), the returns from the FP unit.
REQ-009 The block SHALL have port rsp_valid, output, 1, response valid.
REQ-010 The block SHALL have port rsp_ready, input, 1, response accept.
REQ-011 The block SHALL have port rsp_id, output, 1, index of the requester owning the response.
REQ-012 The block SHALL have port rsp_data, output, 64, the result.
REQ-013 The block SHALL have ports rsp_overflow (output, 1) and rsp_err (output, 1), response status flags.
REQ-014 The block SHALL have port done_count, output, 16, the count of completed responses.

Function
REQ-015 The block SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-016 In IDLE, req_ready SHALL be combinational: with one requester valid it is granted; with both valid the one not granted last is granted (round-robin pointer, reset to favour requester 0).
REQ-017 A handshake (req_valid[i] & req_ready[i]) SHALL latch the command and id, update the round-robin pointer to i, and move to ISSUE the next cycle.
REQ-018 In ISSUE, the block SHALL drive the latched op, mode, x and y on fpu_* for exactly LATENCY cycles, using a 4-bit down-counter.
REQ-019 On the last ISSUE cycle edge, the block SHALL capture rsp_data and rsp_overflow, then enter RESP.
REQ-020 rsp_data SHALL be {32'b0, fpu_result32} when mode=0 and fpu_result64 when mode=1.
REQ-021 Outside ISSUE, fpu_operation SHALL be 0 (idle) and fpu_x, fpu_y and fpu_mode SHALL hold their last values.
REQ-022 An accepted op of 0 or 3 SHALL skip ISSUE: the block enters RESP the next cycle with rsp_data=0, rsp_overflow=0, rsp_err=1.
REQ-023 In RESP, rsp_valid=1 and rsp_data, rsp_id, rsp_overflow and rsp_err SHALL be stable until rsp_ready.
REQ-024 On rsp_valid & rsp_ready, the block SHALL return to IDLE and increment done_count, which wraps at 16'hFFFF->0.
REQ-025 req_ready SHALL be 0 in ISSUE and RESP; no new grant SHALL occur in the same cycle a response completes.
REQ-026 Accept-to-rsp_valid latency SHALL be LATENCY+1 cycles for a legal op and 1 cycle for an illegal op.
REQ-027 A requester dropping req_valid before grant SHALL lose nothing; the pointer SHALL be unchanged without a handshake.

Reset
REQ-028 When rst=1, the block SHALL enter IDLE and set req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_overflow=0, rsp_err=0, done_count=0, fpu_operation=0, fpu_mode=0, fpu_x=0, fpu_y=0, and pointer favouring requester 0.
REQ-029 Reset asserted mid-ISSUE or mid-RESP SHALL abort the operation; no response is produced and done_count is not incremented.

Verification
REQ-030 Single add: req0 op=1 mode=0 x=32'h3F800000 y=32'h40000000, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_id=0, rsp_data=64'h0000_0000_4040_0000.
REQ-031 Contention: both valid every cycle for 4 ops -> grants alternate 0,1,0,1, and done_count=4.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp fields stable, req_ready=0 throughout, and a single completion when released.
REQ-033 Illegal op: req1 op=3 -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0, and fpu_operation never non-zero.
REQ-034 Double mul with overflow: mode=1 and the FP unit returning overflow=1 -> rsp_overflow=1, rsp_data=fpu_result64.
REQ-035 Reset mid-ISSUE -> next cycle IDLE, fpu_operation=0, no rsp_valid, done_count unchanged at 0.
